// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit 8-segment display: latches content through a LOAD strobe,
// applies it only at frame boundaries, and drives DIGIT/SEG with a blank gap between digits.
module seg_scan_ctrl #(
  parameter int CLK_DIV          = 50000,
  parameter int BLANK_CYCLES     = 64,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VALUE,
  input  logic [3:0]  DP,
  input  logic [3:0]  MASK,
  input  logic        LOAD,
  output logic        PENDING,
  output logic        FRAME,
  output logic [7:0]  SEG,
  output logic [3:0]  DIGIT
);

  localparam int CMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DRV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : {CW{1'b0}};
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0] DIG_OFF = DIGIT_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          wrap, apply;

  logic [15:0] act_value, pend_value, act_value_nxt;
  logic [3:0]  act_dp, pend_dp, act_dp_nxt;
  logic [3:0]  act_mask, pend_mask, act_mask_nxt;

  logic [7:0] seg_lit, seg_nxt;
  logic [3:0] dig_on, dig_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    wrap      = 1'b0;
    case (state)
      BLANK: begin
        // With no blank gap this state only occurs once, right after reset.
        if (BLANK_CYCLES == 0 || cnt == BLK_LAST) begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (cnt == DRV_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
          wrap      = (idx == 2'd3);
          state_nxt = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end
      end
      default: state_nxt = BLANK;
    endcase

    apply         = wrap && PENDING;
    act_value_nxt = apply ? pend_value : act_value;
    act_dp_nxt    = apply ? pend_dp    : act_dp;
    act_mask_nxt  = apply ? pend_mask  : act_mask;

    // Outputs are computed from the next state and next active content so they
    // change on the same edge that enters the state.
    seg_lit = 8'h00;
    dig_on  = 4'h0;
    if (state_nxt == DRIVE && act_mask_nxt[idx_nxt]) begin
      dig_on  = 4'b0001 << idx_nxt;
      seg_lit = {act_dp_nxt[idx_nxt], hex7(act_value_nxt[idx_nxt*4 +: 4])};
    end
    seg_nxt = SEG_ACTIVE_LOW   ? ~seg_lit : seg_lit;
    dig_nxt = DIGIT_ACTIVE_LOW ? ~dig_on  : dig_on;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= 2'd0;
      act_value  <= 16'h0000;
      act_dp     <= 4'h0;
      act_mask   <= 4'h0;
      pend_value <= 16'h0000;
      pend_dp    <= 4'h0;
      pend_mask  <= 4'h0;
      PENDING    <= 1'b0;
      FRAME      <= 1'b0;
      SEG        <= SEG_OFF;
      DIGIT      <= DIG_OFF;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      act_value <= act_value_nxt;
      act_dp    <= act_dp_nxt;
      act_mask  <= act_mask_nxt;
      if (LOAD) begin
        pend_value <= VALUE;
        pend_dp    <= DP;
        pend_mask  <= MASK;
      end
      // A LOAD on the apply edge keeps PENDING set for the newly captured content.
      if (LOAD)
        PENDING <= 1'b1;
      else if (wrap)
        PENDING <= 1'b0;
      FRAME <= wrap;
      SEG   <= seg_nxt;
      DIGIT <= dig_nxt;
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit, 8-segment common-anode display on the board. It latches a 16-bit hex value, per-digit decimal points and a digit-enable mask through a load handshake. It applies new content only at frame boundaries, so a frame never shows a mix of old and new content. It cycles the DIGIT enables with an anti-ghosting blank gap and drives SEG from an internal hex-to-7-segment decoder. It sits between the control or status logic and the SEG/DIGIT board pins.

Parameters:
CLK_DIV, 50000, CLK cycles each digit is driven (DRIVE slot length); must be >= 1
BLANK_CYCLES, 64, CLK cycles of all-off between digits; 0 = no gap
SEG_ACTIVE_LOW, 1, 1: a lit segment is driven 0
DIGIT_ACTIVE_LOW, 1, 1: an enabled digit is driven 0

Ports:
CLK  in  1  system clock, single clock domain
RST  in  1  asynchronous, active-high reset
VALUE  in  16  four hex nibbles; VALUE[3:0] = digit 0 (rightmost)
DP  in  4  decimal point per digit; DP[i] belongs to digit i
MASK  in  4  digit enable; 0 = digit i stays dark
LOAD  in  1  one-cycle strobe; captures VALUE/DP/MASK into the pending register
PENDING  out  1  high from the LOAD capture until the content is applied
FRAME  out  1  one-cycle pulse at each frame boundary
SEG  out  8  SEG[7] = dp, SEG[6:0] = g,f,e,d,c,b,a
DIGIT  out  4  digit select; DIGIT[i] drives digit i

Behaviour:
- Reset (async assert, sync release):
  - Active and pending registers = 0; MASK_active = 4'b0000, so the display is dark until the first apply.
  - PENDING = 0, FRAME = 0, idx = 0, state = BLANK, cnt = 0.
  - SEG and DIGIT at their "off" level (8'hFF and 4'hF with the default parameters).
- Reset mid-scan aborts immediately to the reset values. Any pending content is discarded.
- State machine, per digit idx (0..3):
  - BLANK: lasts BLANK_CYCLES cycles. DIGIT and SEG are all off. If BLANK_CYCLES = 0, the state is skipped.
  - DRIVE: lasts CLK_DIV cycles. DIGIT selects only idx, and only if MASK_active[idx] = 1; otherwise DIGIT stays all off but the slot time is kept, so brightness is uniform.
  - DRIVE SEG = decode(nibble idx of VALUE_active) with the dp bit = DP_active[idx]. The dp bit is lit even on a masked digit? No: a masked digit drives SEG off as well.
  - BLANK to DRIVE when cnt reaches BLANK_CYCLES-1. DRIVE to BLANK of idx+1 when cnt reaches CLK_DIV-1. cnt clears on every state change.
- idx wraps 3 to 0. Frame period = 4*(BLANK_CYCLES+CLK_DIV) cycles.
- Outputs are registered. SEG and DIGIT take their new values on the same edge that enters the new state, so there is no extra pipeline latency.
- Decoder is full hex 0-F:
  - Segment codes in {g..a} order: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Codes are logically inverted when SEG_ACTIVE_LOW = 1.
- Load handshake:
  - LOAD = 1 on edge t: the pending registers take VALUE/DP/MASK and PENDING = 1 from t+1.
  - LOAD while PENDING = 1 overwrites the pending registers (last load wins).
  - LOAD may be held high; it recaptures every cycle.
- Apply: on the edge where digit 3's DRIVE ends (idx wraps to 0):
  - FRAME pulses high for exactly 1 cycle.
  - If PENDING = 1, the active registers are loaded from pending and PENDING clears.
- Simultaneous LOAD and apply on the same edge: the apply uses the old pending contents, the new LOAD is captured into pending, and PENDING stays 1. The new content applies at the next frame.
- The active registers never change except at an apply edge, so there is no tearing within a frame.

Test Plan:
1. CLK_DIV=4, BLANK_CYCLES=2, RST pulse mid-run → SEG=8'hFF, DIGIT=4'hF, PENDING=0 immediately, no CLK edge needed. After release, the display is dark for a whole frame (MASK_active=0) and FRAME pulses every 24 cycles.
2. LOAD VALUE=16'h1234, DP=4'b0100, MASK=4'hF → PENDING=1 until the next FRAME edge. Next frame, each digit is driven for 4 cycles after a 2-cycle blank:
   - idx0 DIGIT=4'b1110, SEG=~8'h66 ("4")
   - idx1 SEG=~8'h4F
   - idx2 DIGIT=4'b1011, SEG=~8'hDB ("2" with dp)
   - idx3 SEG=~8'h06
3. LOAD 16'hABCD in the middle of digit 1's slot → remaining digits of the current frame still show 1234. From the next frame, the display shows d,C,b,A (SEG=~5E,~39,~7C,~77).
4. MASK=4'b0101 → DIGIT stays 4'hF during the idx1 and idx3 slots, and the slot timing is unchanged (still 24-cycle frame).
5. LOAD 16'h0001 then LOAD 16'h0002 before the boundary → only 0002 is ever displayed. A LOAD coinciding with the apply edge leaves PENDING=1 and shows its value one frame later.
6. BLANK_CYCLES=0, CLK_DIV=1 → DIGIT steps 1110, 1101, 1011, 0111 on consecutive cycles and FRAME pulses every 4 cycles.
